debounced_priority_encoder: RTL and testbench

- 8-to-3 priority encoder, the encoding counterpart of the board-level 3-to-8 switch decoder.
- Samples eight asynchronous slide switches or push-buttons, synchronises and debounces them, then encodes the highest-index active input into a registered 3-bit code with a valid flag.
- Pulses a change strobe whenever the encoded result changes.
- Sits between the raw board inputs (SW) and downstream logic or the 3-to-8 LED decoder, so a loop-back SW→encoder→decoder→LEDG is a standard board test.

---
 rtl/debounced_priority_encoder.sv | 82 ++++++++
 tb/tb_debounced_priority_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/debounced_priority_encoder.sv
// 8-to-3 priority encoder for raw board switches.
// Each bit passes through a 2-flop synchroniser. The whole 8-bit vector is then
// debounced as a unit. The highest set bit is encoded into a registered code
// with a valid flag, and CHANGE pulses for one cycle whenever that result changes.
module debounced_priority_encoder #(
    parameter int unsigned DEBOUNCE = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] SW,
    output logic [2:0] CODE,
    output logic       VALID,
    output logic       CHANGE,
    output logic [7:0] STABLE
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       enc;
    logic             val;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= SW;
            s2 <= s1;
        end
    end

    // Whole-vector debounce.
    // Any bit that differs from the candidate restarts the count.
    // The count saturates once the candidate has been held long enough, and
    // from then on the candidate is loaded into STABLE.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cand   <= '0;
            cnt    <= '0;
            STABLE <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else begin
            STABLE <= cand;
        end
    end

    // Priority encode the debounced vector; the highest index wins.
    always_comb begin
        enc = '0;
        val = |STABLE;
        for (int unsigned i = 0; i < 8; i++) begin
            if (STABLE[i]) begin
                enc = 3'(i);
            end
        end
    end

    // Register the code and valid flag.
    // CHANGE is asserted in the same cycle that a new result first appears.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            CODE   <= '0;
            VALID  <= 1'b0;
            CHANGE <= 1'b0;
        end else begin
            CODE   <= enc;
            VALID  <= val;
            CHANGE <= ({val, enc} != {VALID, CODE});
        end
    end

endmodule

// File: tb/tb_debounced_priority_encoder.sv
// Directed testbench for debounced_priority_encoder with DEBOUNCE=4.
// With that setting, a steady input shows up on CODE/VALID 8 rising edges after it is applied.
module tb_debounced_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [2:0] code;
    logic       valid;
    logic       change;
    logic [7:0] stable;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned pulses;
    logic        prev_change;
    logic        consec_seen;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] code;
        logic       valid;
        logic [7:0] stable;
    } vec_t;

    vec_t vecs[9];

    debounced_priority_encoder #(
        .DEBOUNCE (4),
        .CNT_W    (16)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (sw),
        .CODE     (code),
        .VALID    (valid),
        .CHANGE   (change),
        .STABLE   (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count CHANGE pulses just after each rising edge.
    // Also flag any back-to-back pulses.
    always @(posedge clk) begin
        #1;
        if (change) pulses++;
        if (change && prev_change) consec_seen = 1'b1;
        prev_change = change;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned p0;
        n_vec = 0;
        n_err = 0;
        pulses = 0;
        prev_change = 1'b0;
        consec_seen = 1'b0;

        vecs[0] = '{8'h01, 3'd0, 1'b1, 8'h01};
        vecs[1] = '{8'h02, 3'd1, 1'b1, 8'h02};
        vecs[2] = '{8'h04, 3'd2, 1'b1, 8'h04};
        vecs[3] = '{8'h08, 3'd3, 1'b1, 8'h08};
        vecs[4] = '{8'h10, 3'd4, 1'b1, 8'h10};
        vecs[5] = '{8'h20, 3'd5, 1'b1, 8'h20};
        vecs[6] = '{8'h40, 3'd6, 1'b1, 8'h40};
        vecs[7] = '{8'h80, 3'd7, 1'b1, 8'h80};
        vecs[8] = '{8'h00, 3'd0, 1'b0, 8'h00};

        // 1. Reset with all switches on, then release.
        rst_n = 1'b0;
        sw    = 8'hFF;
        tick(3);
        check("rst_code",   8'(code),   8'h00);
        check("rst_valid",  8'(valid),  8'h00);
        check("rst_change", 8'(change), 8'h00);
        check("rst_stable", stable,     8'h00);
        rst_n = 1'b1;
        tick(7);
        check("rel_code_early",  8'(code),  8'h00);
        check("rel_stable_early", stable,   8'hFF);
        tick(1);
        check("rel_code",   8'(code),   8'h07);
        check("rel_valid",  8'(valid),  8'h01);
        check("rel_stable", stable,     8'hFF);
        check("rel_change", 8'(change), 8'h01);
        tick(1);
        check("rel_change_off", 8'(change), 8'h00);

        // 2. Walk a single bit from 0 to 7, then clear all switches.
        for (int i = 0; i < 9; i++) begin
            p0 = pulses;
            sw = vecs[i].sw;
            tick(12);
            check("walk_code",   8'(code),  8'(vecs[i].code));
            check("walk_valid",  8'(valid), 8'(vecs[i].valid));
            check("walk_stable", stable,    vecs[i].stable);
            check("walk_pulses", 8'(pulses - p0), 8'd1);
        end

        // 3. A lower-priority change under a held bit 7.
        sw = 8'h90;
        tick(12);
        check("lp_code0", 8'(code), 8'h07);
        p0 = pulses;
        sw = 8'h93;
        tick(6);
        check("lp_stable_early", stable, 8'h90);
        tick(1);
        check("lp_stable", stable, 8'h93);
        tick(6);
        check("lp_code",   8'(code), 8'h07);
        check("lp_pulses", 8'(pulses - p0), 8'd0);

        // 4. A 3-cycle glitch is rejected; an 8-cycle pulse is accepted.
        sw = 8'h01;
        tick(12);
        p0 = pulses;
        sw = 8'h40;
        tick(3);
        sw = 8'h01;
        tick(12);
        check("gl_stable", stable, 8'h01);
        check("gl_code",   8'(code), 8'h00);
        check("gl_pulses", 8'(pulses - p0), 8'd0);
        p0 = pulses;
        sw = 8'h40;
        tick(8);
        check("pl_code_hi", 8'(code), 8'h06);
        sw = 8'h01;
        tick(12);
        check("pl_code_lo", 8'(code), 8'h00);
        check("pl_pulses",  8'(pulses - p0), 8'd2);

        // 5. Bit 5 bounces every 2 cycles, then settles high.
        sw = 8'h00;
        tick(12);
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            sw = 8'h20;
            tick(2);
            sw = 8'h00;
            tick(2);
        end
        sw = 8'h20;
        tick(7);
        check("bn_code_early",  8'(code),  8'h00);
        check("bn_valid_early", 8'(valid), 8'h00);
        tick(1);
        check("bn_code",   8'(code),   8'h05);
        check("bn_valid",  8'(valid),  8'h01);
        check("bn_change", 8'(change), 8'h01);
        tick(4);
        check("bn_pulses", 8'(pulses - p0), 8'd1);

        // 6. Asynchronous reset in the middle of a debounce.
        sw = 8'h08;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_code",   8'(code),   8'h00);
        check("ar_valid",  8'(valid),  8'h00);
        check("ar_stable", stable,     8'h00);
        check("ar_change", 8'(change), 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(7);
        check("ar_code_early", 8'(code), 8'h00);
        tick(1);
        check("ar_code_rel",   8'(code),   8'h03);
        check("ar_valid_rel",  8'(valid),  8'h01);
        check("ar_change_rel", 8'(change), 8'h01);
        tick(1);
        check("ar_change_off", 8'(change), 8'h00);

        check("no_consec_change", 8'(consec_seen), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
